fetch_stage: RTL and testbench

- Instruction-fetch stage that sits directly downstream of the 32-bit PC register: consumes PCResult and drives NextAddress back into the PC's Address input.
- The PC register has no enable, so this block stalls the PC by feeding PCResult back.
- Fetches from instruction memory over a req/ack handshake that tolerates variable latency, then loads the IF/ID pipeline register.
- Handles hazard stalls and branch/jump redirects (flush).

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC's next address, fetches over a
// variable-latency req/ack interface and loads the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] PC_INCR   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    output logic [31:0] NextAddress,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemData,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid
);

    typedef enum logic [1:0] {
        ISSUE,
        REQ,
        HOLD
    } state_t;

    state_t      state, state_next;
    logic        squash, squash_next;
    logic [31:0] buf_instr, buf_instr_next;
    logic [31:0] buf_pc4, buf_pc4_next;
    logic        req_next;
    logic [31:0] addr_next;
    logic [31:0] ifid_instr_next, ifid_pc4_next;
    logic        ifid_valid_next;

    logic        accept;
    logic [31:0] seq_addr;
    logic        load;
    logic [31:0] load_instr, load_pc4;

    assign accept   = (state == REQ) && ImemAck;
    assign seq_addr = ImemAddr + PC_INCR;

    // The PC register has no enable: feeding PCResult back is how it stalls.
    always_comb begin
        if (Reset) begin
            NextAddress = '0;
        end else if (Redirect) begin
            NextAddress = RedirectTarget;
        end else if (accept && !squash) begin
            NextAddress = seq_addr;
        end else begin
            NextAddress = PCResult;
        end
    end

    always_comb begin
        state_next     = state;
        squash_next    = squash;
        buf_instr_next = buf_instr;
        buf_pc4_next   = buf_pc4;
        req_next       = ImemReq;
        addr_next      = ImemAddr;
        load           = 1'b0;
        load_instr     = ImemData;
        load_pc4       = seq_addr;

        unique case (state)
            ISSUE: begin
                if (!Redirect) begin
                    addr_next  = PCResult;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ImemAck) begin
                    if (squash || Redirect) begin
                        squash_next = 1'b0;
                        req_next    = 1'b0;
                        state_next  = ISSUE;
                    end else if (Stall) begin
                        // PC already advanced; park the word until ID frees up.
                        buf_instr_next = ImemData;
                        buf_pc4_next   = seq_addr;
                        req_next       = 1'b0;
                        state_next     = HOLD;
                    end else begin
                        load      = 1'b1;
                        addr_next = seq_addr;
                    end
                end else if (Redirect) begin
                    squash_next = 1'b1;
                end
            end
            HOLD: begin
                if (Redirect) begin
                    state_next = ISSUE;
                end else if (!Stall) begin
                    load       = 1'b1;
                    load_instr = buf_instr;
                    load_pc4   = buf_pc4;
                    addr_next  = PCResult;
                    req_next   = 1'b1;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = ISSUE;
                req_next   = 1'b0;
            end
        endcase

        ifid_instr_next = IfIdInstruction;
        ifid_pc4_next   = IfIdPCPlus4;
        ifid_valid_next = IfIdValid;
        if (Redirect) begin
            ifid_instr_next = NOP_INSTR;
            ifid_valid_next = 1'b0;
        end else if (load) begin
            ifid_instr_next = load_instr;
            ifid_pc4_next   = load_pc4;
            ifid_valid_next = 1'b1;
        end else if (!Stall) begin
            ifid_instr_next = NOP_INSTR;
            ifid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state           <= ISSUE;
            squash          <= 1'b0;
            buf_instr       <= NOP_INSTR;
            buf_pc4         <= '0;
            ImemReq         <= 1'b0;
            ImemAddr        <= '0;
            IfIdInstruction <= NOP_INSTR;
            IfIdPCPlus4     <= '0;
            IfIdValid       <= 1'b0;
        end else begin
            state           <= state_next;
            squash          <= squash_next;
            buf_instr       <= buf_instr_next;
            buf_pc4         <= buf_pc4_next;
            ImemReq         <= req_next;
            ImemAddr        <= addr_next;
            IfIdInstruction <= ifid_instr_next;
            IfIdPCPlus4     <= ifid_pc4_next;
            IfIdValid       <= ifid_valid_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// reset/zero-wait sequences, and randomized traffic against a flag-based model.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        Clk = 1'b0;
    logic        Reset, ImemAck, Stall, Redirect;
    logic [31:0] PCResult, NextAddress, ImemAddr, ImemData, RedirectTarget;
    logic        ImemReq, IfIdValid;
    logic [31:0] IfIdInstruction, IfIdPCPlus4;
    logic        use_rnd;
    logic [31:0] rnd_data;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 Clk = ~Clk;

    // The PC register this stage feeds.
    always_ff @(posedge Clk) PCResult <= NextAddress;

    // Memory returns a word derived from the address it is asked for.
    assign ImemData = use_rnd ? rnd_data : (ImemAddr ^ KEY);

    fetch_stage #(.PC_INCR(32'd4), .NOP_INSTR(32'h0000_0000)) dut (
        .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .NextAddress(NextAddress),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(ImemData),
        .Stall(Stall), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
        .IfIdInstruction(IfIdInstruction), .IfIdPCPlus4(IfIdPCPlus4), .IfIdValid(IfIdValid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic ack, input logic stall,
                         input logic redir, input logic [31:0] tgt);
        Reset = rst; ImemAck = ack; Stall = stall; Redirect = redir; RedirectTarget = tgt;
        #1;
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    typedef struct {
        logic        ack, stall, redir;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc4;
        logic [31:0] e_next;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic a, input logic s, input logic r, input logic [31:0] t,
                       input logic eq, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ep, input logic [31:0] en);
        vec_t v;
        v.ack = a; v.stall = s; v.redir = r; v.tgt = t;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc4 = ep; v.e_next = en;
        vecs.push_back(v);
    endtask

    // Reference model: outstanding-request / parked-word / drop flags.
    logic        m_busy, m_parked, m_drop, m_v;
    logic [31:0] m_addr, m_pc, m_park_i, m_park_p, m_i, m_p;

    task automatic model_reset();
        m_busy = 0; m_parked = 0; m_drop = 0; m_v = 0;
        m_addr = 0; m_pc = 0; m_i = 0; m_p = 0; m_park_i = 0; m_park_p = 0;
    endtask

    function automatic logic [31:0] model_next(input logic rst, input logic ack,
                                               input logic redir, input logic [31:0] tgt);
        if (rst) return 32'd0;
        if (redir) return tgt;
        if (m_busy && ack && !m_drop) return m_addr + 32'd4;
        return m_pc;
    endfunction

    task automatic model_step(input logic rst, input logic ack, input logic stall,
                              input logic redir, input logic [31:0] tgt, input logic [31:0] data);
        logic        got, fresh, give;
        logic [31:0] gi, gp, npc;
        if (rst) begin
            model_reset();
            return;
        end
        npc   = model_next(rst, ack, redir, tgt);
        got   = m_busy && ack;
        fresh = got && !m_drop && !redir;
        give  = 0; gi = 0; gp = 0;
        if (m_busy) begin
            if (got) begin
                if (m_drop || redir) begin
                    m_busy = 0; m_drop = 0;
                end else if (stall) begin
                    m_busy = 0; m_parked = 1; m_park_i = data; m_park_p = m_addr + 32'd4;
                end else begin
                    give = 1; gi = data; gp = m_addr + 32'd4; m_addr = m_addr + 32'd4;
                end
            end else if (redir) begin
                m_drop = 1;
            end
        end else if (m_parked) begin
            if (redir) begin
                m_parked = 0;
            end else if (!stall) begin
                give = 1; gi = m_park_i; gp = m_park_p;
                m_parked = 0; m_busy = 1; m_addr = m_pc;
            end
        end else if (!redir) begin
            m_busy = 1; m_addr = m_pc;
        end
        if (fresh && give == 0) give = 0;
        if (redir) begin
            m_v = 0; m_i = 0;
        end else if (give) begin
            m_v = 1; m_i = gi; m_p = gp;
        end else if (!stall) begin
            m_v = 0; m_i = 0;
        end
        m_pc = npc;
    endtask

    initial begin
        use_rnd = 0; rnd_data = 0;
        drive(1, 0, 0, 0, 0);
        step();

        // Reset values, with a redirect pending to prove reset dominates NextAddress.
        drive(1, 1, 0, 1, 32'h0000_0055);
        step();
        drive(1, 1, 0, 1, 32'h0000_0055);
        check("rst_req", {31'd0, ImemReq}, 32'd0);
        check("rst_addr", ImemAddr, 32'd0);
        check("rst_valid", {31'd0, IfIdValid}, 32'd0);
        check("rst_instr", IfIdInstruction, 32'd0);
        check("rst_pc4", IfIdPCPlus4, 32'd0);
        check("rst_next", NextAddress, 32'd0);
        step();

        // Zero-wait memory: one instruction per cycle after the issue cycle.
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 0, 0);
            check("zw_req", {31'd0, ImemReq}, (k == 0) ? 32'd0 : 32'd1);
            if (k >= 1) check("zw_addr", ImemAddr, 32'(4 * (k - 1)));
            check("zw_next", NextAddress, 32'(4 * k));
            if (k >= 2) begin
                check("zw_valid", {31'd0, IfIdValid}, 32'd1);
                check("zw_pc4", IfIdPCPlus4, 32'(4 * (k - 1)));
                check("zw_instr", IfIdInstruction, 32'(4 * (k - 2)) ^ KEY);
            end
            step();
        end

        // Reset while a request is outstanding; a late ack must be ignored.
        drive(0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 0, 0);
        step();
        drive(0, 1, 0, 0, 0);
        check("mr_req", {31'd0, ImemReq}, 32'd0);
        check("mr_addr", ImemAddr, 32'd0);
        check("mr_valid", {31'd0, IfIdValid}, 32'd0);
        check("mr_instr", IfIdInstruction, 32'd0);
        check("mr_late_ack_next", NextAddress, 32'd0);
        step();
        drive(0, 0, 0, 0, 0);
        check("mr_restart_req", {31'd0, ImemReq}, 32'd1);
        check("mr_restart_addr", ImemAddr, 32'd0);
        step();
        drive(1, 0, 0, 0, 0);
        step();

        // Directed table: latency, stall/hold, redirect while waiting, redirect on ack,
        // redirect+stall in hold, and address wraparound.
        add(0,0,0,0,          0,32'h000,0,0,32'h000);
        add(0,0,0,0,          1,32'h000,0,0,32'h000);
        add(0,0,0,0,          1,32'h000,0,0,32'h000);
        add(1,0,0,0,          1,32'h000,0,0,32'h004);
        add(0,0,0,0,          1,32'h004,1,32'h004,32'h004);
        add(1,0,0,0,          1,32'h004,0,0,32'h008);
        add(1,1,0,0,          1,32'h008,1,32'h008,32'h00C);
        add(0,1,0,0,          0,32'h008,1,32'h008,32'h00C);
        add(0,0,0,0,          0,32'h008,1,32'h008,32'h00C);
        add(0,0,1,32'h100,    1,32'h00C,1,32'h00C,32'h100);
        add(0,0,0,0,          1,32'h00C,0,0,32'h100);
        add(1,0,0,0,          1,32'h00C,0,0,32'h100);
        add(0,0,0,0,          0,32'h00C,0,0,32'h100);
        add(1,0,0,0,          1,32'h100,0,0,32'h104);
        add(1,0,1,32'h200,    1,32'h104,1,32'h104,32'h200);
        add(0,0,0,0,          0,32'h104,0,0,32'h200);
        add(1,1,0,0,          1,32'h200,0,0,32'h204);
        add(0,1,1,32'h300,    0,32'h200,0,0,32'h300);
        add(0,0,0,0,          0,32'h200,0,0,32'h300);
        add(1,0,0,0,          1,32'h300,0,0,32'h304);
        add(1,0,0,0,          1,32'h304,1,32'h304,32'h308);
        add(0,0,1,32'hFFFF_FFFC, 1,32'h308,1,32'h308,32'hFFFF_FFFC);
        add(1,0,0,0,          1,32'h308,0,0,32'hFFFF_FFFC);
        add(0,0,0,0,          0,32'h308,0,0,32'hFFFF_FFFC);
        add(1,0,0,0,          1,32'hFFFF_FFFC,0,0,32'h000);
        add(0,0,0,0,          1,32'h000,1,32'h000,32'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].ack, vecs[i].stall, vecs[i].redir, vecs[i].tgt);
            check($sformatf("v%0d_req", i), {31'd0, ImemReq}, {31'd0, vecs[i].e_req});
            check($sformatf("v%0d_addr", i), ImemAddr, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {31'd0, IfIdValid}, {31'd0, vecs[i].e_valid});
            check($sformatf("v%0d_instr", i), IfIdInstruction,
                  vecs[i].e_valid ? ((vecs[i].e_pc4 - 32'd4) ^ KEY) : 32'd0);
            if (vecs[i].e_valid) check($sformatf("v%0d_pc4", i), IfIdPCPlus4, vecs[i].e_pc4);
            check($sformatf("v%0d_next", i), NextAddress, vecs[i].e_next);
            step();
        end

        // Randomized traffic against the reference model.
        use_rnd = 1;
        drive(1, 0, 0, 0, 0);
        step();
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            logic        r_rst, r_ack, r_stall, r_redir;
            logic [31:0] r_tgt;
            r_rst   = ($urandom_range(0, 99) < 2);
            r_ack   = ImemReq ? $urandom_range(0, 1) : ($urandom_range(0, 9) == 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_redir = ($urandom_range(0, 11) == 0);
            r_tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4)
                                                  : ($urandom & 32'hFFFF_FFFC);
            rnd_data = $urandom;
            drive(r_rst, r_ack, r_stall, r_redir, r_tgt);
            check("rnd_next", NextAddress, model_next(r_rst, r_ack, r_redir, r_tgt));
            check("rnd_req", {31'd0, ImemReq}, {31'd0, m_busy});
            if (m_busy) check("rnd_addr", ImemAddr, m_addr);
            check("rnd_valid", {31'd0, IfIdValid}, {31'd0, m_v});
            check("rnd_instr", IfIdInstruction, m_i);
            if (m_v) check("rnd_pc4", IfIdPCPlus4, m_p);
            model_step(r_rst, r_ack, r_stall, r_redir, r_tgt, rnd_data);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
